// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_seq_unit.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ASR = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_SIGN,
    S_FIN
  } state_t;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

endpackage

// File: rtl/alu_seq_unit_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  // Upper half accumulates; the multiplier is consumed from the low half as it shifts out.
  assign sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  // High while the final step is executing; prod is complete after this edge.
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (start) begin
      prod  <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= CW'(WIDTH);
    end else if (cnt != '0) begin
      prod  <= {sum, prod[WIDTH-1:1]};
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered sequential ALU with iterative signed multiply and N/Z/C/V flags.
// Define ALU_SAT_EN to saturate overflowing ADD/SUB results instead of wrapping.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] Mem_Data_X,
  input  logic [WIDTH-1:0] Mem_Data_Y,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_HI,
  output logic [3:0]       FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int MSB = WIDTH - 1;

  state_t             state, state_nxt;
  logic [3:0]         op;
  logic               mul_start, mul_last;
  logic [WIDTH-1:0]   mag_x, mag_y;
  logic [2*WIDTH-1:0] mul_prod, prod_s;
  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, asr_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err;
  logic [3:0]         alu_flags, mul_flags;

  assign mul_start = (state == S_IDLE) && START && (OP == OP_MUL);
  assign mag_x     = Mem_Data_X[MSB] ? -Mem_Data_X : Mem_Data_X;
  assign mag_y     = Mem_Data_Y[MSB] ? -Mem_Data_Y : Mem_Data_Y;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (mul_start),
    .a     (mag_x),
    .b     (mag_y),
    .prod  (mul_prod),
    .done  (mul_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = (OP == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  state_nxt = S_FIN;
      S_MUL:   if (mul_last) state_nxt = S_SIGN;
      S_SIGN:  state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign BUSY = (state != S_IDLE);
  assign DONE = (state == S_FIN);

  // Shifts run one bit wider so the last bit shifted out lands in bit WIDTH (left) or bit 0 (right).
  assign amt   = Y[SHW-1:0];
  assign add_w = {1'b0, X} + {1'b0, Y};
  assign sub_w = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_w = {1'b0, X} << amt;
  assign shr_w = {X, 1'b0} >> amt;
  assign asr_w = $signed({X, 1'b0}) >>> amt;

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_err   = 1'b0;
    alu_flags = '0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[MSB:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (X[MSB] == Y[MSB]) && (add_w[MSB] != X[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_w[MSB:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (X[MSB] != Y[MSB]) && (sub_w[MSB] != X[MSB]);
      end
      OP_AND: alu_res = X & Y;
      OP_OR:  alu_res = X | Y;
      OP_XOR: alu_res = X ^ Y;
      OP_NOT: alu_res = ~X;
      OP_SHL: begin
        alu_res = shl_w[MSB:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[WIDTH:1];
        alu_c   = asr_w[0];
      end
      OP_MUL: ;
      default: alu_err = 1'b1;
    endcase
`ifdef ALU_SAT_EN
    if (((op == OP_ADD) || (op == OP_SUB)) && alu_v)
      alu_res = X[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    if (!alu_err) begin
      alu_flags[F_N] = alu_res[MSB];
      alu_flags[F_Z] = (alu_res == '0);
      alu_flags[F_C] = alu_c;
      alu_flags[F_V] = alu_v;
    end
  end

  always_comb begin
    prod_s         = (X[MSB] ^ Y[MSB]) ? -mul_prod : mul_prod;
    mul_flags      = '0;
    mul_flags[F_N] = prod_s[2*WIDTH-1];
    mul_flags[F_Z] = (prod_s == '0);
    mul_flags[F_V] = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[MSB]}});
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      X     <= '0;
      Y     <= '0;
      Z     <= '0;
      Z_HI  <= '0;
      FLAGS <= '0;
      ERR   <= 1'b0;
      op    <= '0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          X   <= Mem_Data_X;
          Y   <= Mem_Data_Y;
          op  <= OP;
          ERR <= 1'b0;
        end
        S_EXEC: begin
          if (op != OP_CMP) begin
            Z    <= alu_res;
            Z_HI <= '0;
          end
          FLAGS <= alu_flags;
          ERR   <= alu_err;
        end
        S_SIGN: begin
          Z     <= prod_s[MSB:0];
          Z_HI  <= prod_s[2*WIDTH-1:WIDTH];
          FLAGS <= mul_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
